// File: rtl/tdm_demux1_4.sv
// Receive-side 1:4 TDM demultiplexer: locks to a per-frame SYNC marker and
// reassembles four WIDTH-bit channel words from a slot-interleaved bit stream.

module tdm_demux1_4_lane #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] word_q
);
  logic [WIDTH-1:0] word_d;

  always_comb word_d = shift_en ? {word_q[WIDTH-2:0], din} : word_q;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) word_q <= '0;
    else        word_q <= word_d;
endmodule

module tdm_demux1_4 #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               IN,
  input  logic               IN_VALID,
  input  logic               SYNC,
  output logic [1:0]         SL,
  output logic [4*WIDTH-1:0] OUT,
  output logic               OUT_VALID,
  output logic               LOCKED,
  output logic               SYNC_ERR
);
  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] BC_LAST = BCW'(WIDTH - 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               sl_q, sl_d;
  logic [BCW-1:0]           bc_q, bc_d;
  logic [4*WIDTH-1:0]       out_q, out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sync_err_q, sync_err_d;
  logic [3:0]               shift_en;
  logic [3:0][WIDTH-1:0]    words_q;
  logic [3:0][WIDTH-1:0]    words_fin;
  logic                     at_start, at_end;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    tdm_demux1_4_lane #(.WIDTH(WIDTH)) u_lane (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .shift_en (shift_en[k]),
      .din      (IN),
      .word_q   (words_q[k])
    );
  end

  assign at_start = (sl_q == 2'd0) && (bc_q == '0);
  assign at_end   = (sl_q == 2'd3) && (bc_q == BC_LAST);

  // The frame-closing beat always lands in ch3, so the captured frame is the
  // current lane contents with that final bit appended to ch3.
  always_comb begin
    words_fin    = words_q;
    words_fin[3] = {words_q[3][WIDTH-2:0], IN};
  end

  always_comb begin
    state_d     = state_q;
    sl_d        = sl_q;
    bc_d        = bc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    shift_en    = '0;
    if (IN_VALID) begin
      case (state_q)
        HUNT: begin
          if (SYNC) begin
            shift_en[0] = 1'b1;
            sl_d        = 2'd1;
            bc_d        = '0;
            state_d     = LOCK;
          end
        end
        LOCK: begin
          if (SYNC && !at_start) begin
            // Misplaced marker restarts the frame on this beat.
            sync_err_d  = 1'b1;
            shift_en[0] = 1'b1;
            sl_d        = 2'd1;
            bc_d        = '0;
          end else if (!SYNC && at_start) begin
            sync_err_d = 1'b1;
            sl_d       = 2'd0;
            bc_d       = '0;
            state_d    = HUNT;
          end else begin
            shift_en[sl_q] = 1'b1;
            sl_d           = sl_q + 2'd1;
            if (sl_q == 2'd3) bc_d = at_end ? '0 : bc_q + 1'b1;
            if (at_end) begin
              out_d       = words_fin;
              out_valid_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= HUNT;
      sl_q        <= '0;
      bc_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sl_q        <= sl_d;
      bc_q        <= bc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign SL        = sl_q;
  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign LOCKED    = (state_q == LOCK);
  assign SYNC_ERR  = sync_err_q;
endmodule

// File: tb/tb_tdm_demux1_4.sv
// Bench for tdm_demux1_4: frame-level stimulus generator with a word scoreboard
// and per-cycle expectations for SL, LOCKED and SYNC_ERR.

module tb_tdm_demux1_4;
  localparam int W  = 4;
  localparam int FB = 4 * W;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN = 1'b0, IN_VALID = 1'b0, SYNC = 1'b0;
  logic [1:0]    SL;
  logic [FB-1:0] OUT;
  logic          OUT_VALID, LOCKED, SYNC_ERR;

  tdm_demux1_4 #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN(IN), .IN_VALID(IN_VALID), .SYNC(SYNC),
    .SL(SL), .OUT(OUT), .OUT_VALID(OUT_VALID), .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  logic [FB-1:0] exp_out_q[$];
  logic [FB-1:0] hold = '0;
  logic [1:0] sl_nxt = '0, sl_cur;
  bit lk_nxt = 0, lk_cur, err_nxt = 0, err_cur;
  bit locked = 0;
  int pos = 0;
  int gap_mode = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectations become current at the edge that samples their beat.
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin sl_cur <= '0; lk_cur <= 0; err_cur <= 0; end
    else begin sl_cur <= sl_nxt; lk_cur <= lk_nxt; err_cur <= err_nxt; end

  always @(negedge CLK) begin
    if (!RST_N) hold = '0;
    cmp("sl", 64'(SL), 64'(sl_cur));
    cmp("locked", 64'(LOCKED), 64'(lk_cur));
    cmp("sync_err", 64'(SYNC_ERR), 64'(err_cur));
    if (OUT_VALID) begin
      if (exp_out_q.size() == 0) cmp("out_valid", 64'(OUT_VALID), 64'd0);
      else begin
        hold = exp_out_q.pop_front();
        cmp("out", 64'(OUT), 64'(hold));
      end
    end else cmp("out_hold", 64'(OUT), 64'(hold));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input bit v, input bit s, input bit d, input bit e);
    IN_VALID = v; SYNC = s; IN = d; err_nxt = e;
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1'($urandom), 1'($urandom), 0);
  endtask

  task automatic beat(input bit s, input bit d, input bit e, input logic [1:0] sl_a, input bit lk_a);
    if (gap_mode == 1) idle(1);
    else if (gap_mode == 2) while ($urandom_range(99) < 30) idle(1);
    sl_nxt = sl_a; lk_nxt = lk_a;
    cyc(1, s, d, e);
  endtask

  // Sends the first n beats of the frame carrying words w; beat 0 carries SYNC.
  task automatic send_frame(input logic [W-1:0] w[4], input int n);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] cw;
      bit e;
      cw = w[i % 4];
      e  = (i == 0) && locked && (pos != 0);
      if (i == FB - 1) exp_out_q.push_back({w[3], w[2], w[1], w[0]});
      beat(i == 0, cw[W-1-i/4], e, 2'((i + 1) % 4), 1);
      locked = 1;
      pos = (i + 1) % FB;
    end
  endtask

  task automatic miss_sync();
    beat(0, 1'($urandom), 1, 2'd0, 0);
    locked = 0; pos = 0;
  endtask

  task automatic garbage(input int n);
    repeat (n) beat(0, 1'($urandom), 0, 2'd0, 0);
  endtask

  task automatic reset_dut();
    RST_N = 0;
    exp_out_q.delete();
    sl_nxt = '0; lk_nxt = 0; err_nxt = 0;
    locked = 0; pos = 0;
    repeat (3) cyc(0, 0, 0, 0);
    RST_N = 1;
  endtask

  logic [W-1:0] w[4];

  initial begin
    reset_dut();
    idle(10);

    w = '{4'hA, 4'h5, 4'hF, 4'h0};
    gap_mode = 0; send_frame(w, FB);
    w = '{4'h1, 4'h2, 4'h3, 4'h4};
    gap_mode = 1; send_frame(w, FB);
    idle(3);

    gap_mode = 0;
    w = '{4'h9, 4'h8, 4'h7, 4'h6};
    send_frame(w, 6);
    w = '{4'hC, 4'h3, 4'hE, 4'h1};
    send_frame(w, FB);

    miss_sync();
    garbage(5);
    w = '{4'h2, 4'hD, 4'h6, 4'hB};
    send_frame(w, FB);

    w = '{4'h5, 4'h5, 4'h5, 4'h5};
    send_frame(w, 9);
    reset_dut();
    w = '{4'h7, 4'h1, 4'h8, 4'hE};
    send_frame(w, FB);

    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(9));
      gap_mode = int'($urandom_range(2));
      for (int k = 0; k < 4; k++) w[k] = W'($urandom);
      if (!locked && r < 3) garbage(int'($urandom_range(1, 4)));
      if (r <= 4) send_frame(w, FB);
      else if (r <= 6) send_frame(w, int'($urandom_range(1, FB - 1)));
      else if (r <= 8) begin
        if (locked && pos == 0) begin
          miss_sync();
          garbage(int'($urandom_range(0, 3)));
        end else send_frame(w, int'($urandom_range(1, FB - 1)));
      end else begin
        send_frame(w, int'($urandom_range(1, FB - 1)));
        reset_dut();
      end
      if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 5)));
    end

    idle(5);
    cmp("pending_frames", 64'(exp_out_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tdm_demux1_4.md
Name: tdm_demux1_4

Overview:
- Sequential inverse of the 4:1 mux: receives a one-bit time-division-multiplexed stream where slots 0..3 rotate across four channels, and rebuilds a WIDTH-bit word per channel.
- Sits at the receive end of a serial link driven by a slot-rotating 4:1 mux.
- Locks to a frame marker (SYNC), tracks the slot and bit position, and presents all four channel words in parallel with a one-cycle valid strobe.

Parameters:
- WIDTH, 8, bits per channel word (2..32).

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN  input  1  serial TDM data bit
- IN_VALID  input  1  IN/SYNC carry a beat this cycle
- SYNC  input  1  frame marker; high on the slot-0, bit-(WIDTH-1) beat of every frame
- SL  output  2  slot the next accepted beat is assigned to
- OUT  output  4*WIDTH  channel k word at OUT[k*WIDTH +: WIDTH]
- OUT_VALID  output  1  one-cycle pulse: OUT updated
- LOCKED  output  1  high while in LOCK state
- SYNC_ERR  output  1  one-cycle pulse on framing error

Behaviour:
- One clock (CLK). Reset asynchronous, active-low (RST_N): all state, SL, OUT, OUT_VALID, LOCKED, SYNC_ERR = 0; FSM = HUNT.
- Beat = any cycle with IN_VALID=1. Cycles with IN_VALID=0 change nothing; OUT_VALID and SYNC_ERR are 0 in the following cycle.
- Frame = 4*WIDTH beats, ordered MSB first and slot-interleaved:
  - ch0 bit W-1, ch1 bit W-1, ch2 bit W-1, ch3 bit W-1, then ch0 bit W-2, and so on.
- Counters:
  - Slot counter (SL) advances by 1 on each accepted beat and wraps 3->0.
  - Bit counter BC starts at 0 and advances when slot 3 is accepted; wraps at WIDTH-1 -> 0.
- Storage: four WIDTH-bit shift registers, one per channel. The accepted bit shifts into the LSB of the register for channel SL.
- FSM HUNT:
  - Beats with SYNC=0 are discarded; SL and BC are held at 0.
  - A beat with SYNC=1 is stored as ch0 MSB. Then SL=1, BC=0, FSM -> LOCK, LOCKED=1 from the next cycle.
- FSM LOCK:
  - Normal beat: SYNC=1 only when SL=0 and BC=0. Stored, counters advance.
  - Frame completion, on the beat with SL=3 and BC=WIDTH-1:
    - At that same edge, OUT is loaded with all four words, including the final bit.
    - OUT_VALID=1 for exactly the next cycle.
    - Counters wrap to 0.
  - Misplaced SYNC (SYNC=1 while SL!=0 or BC!=0):
    - SYNC_ERR pulses; partial frame discarded; OUT unchanged.
    - The beat is taken as the new ch0 MSB: SL=1, BC=0, stay in LOCK.
  - Missing SYNC (SYNC=0 while SL=0 and BC=0):
    - SYNC_ERR pulses; beat discarded; FSM -> HUNT, LOCKED=0, SL=0.
- OUT holds its value until the next completed frame; it is never partially updated.
- Latency: last beat sampled at edge N -> OUT and OUT_VALID valid after edge N. Back-to-back frames with no gaps give an OUT_VALID every 4*WIDTH cycles.
- Reset asserted mid-frame clears everything immediately. After release, the FSM is in HUNT and the partial frame is lost.
- Beats may be non-contiguous: IN_VALID gaps of any length inside a frame do not affect assembly.

Test Plan (WIDTH=4):
- Reset then idle: RST_N=0 for 3 cycles, release, IN_VALID=0 for 10 cycles -> all outputs stay 0, LOCKED=0.
- Single frame, words ch0=A, ch1=5, ch2=F, ch3=0, SYNC on beat 0, 16 contiguous beats:
  - LOCKED=1 after beat 0.
  - OUT=16'h0F5A and OUT_VALID=1 for exactly one cycle after beat 15.
  - SL sequence 1,2,3,0,...
- Two back-to-back frames (second frame ch0..ch3 = 1,2,3,4), the second with IN_VALID low every other cycle -> second OUT=16'h4321 after 16 accepted beats. OUT=0F5A is held between the two strobes.
- SYNC=1 on beat 6 of a frame -> SYNC_ERR pulse; no OUT_VALID for the aborted frame. The following 15 beats complete a new frame with the correct OUT.
- SYNC=0 on the expected frame-start beat -> SYNC_ERR pulse, LOCKED=0, SL=0. Beats ignored until the next SYNC=1 beat relocks.
- RST_N asserted at beat 9, then 16 clean beats -> no OUT_VALID before relock; OUT=0 until that frame completes.
